// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: 2-flop synchroniser, counter debounce,
// one-cycle press/release pulses and optional per-channel auto-repeat.

module btn_chan #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  input  logic repeat_en_in,
  output logic clean_out,
  output logic press_out,
  output logic release_out
);
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;
  localparam logic [DW-1:0] DB_T  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_T = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_T = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  logic          sync1_q, sync2_q;
  logic          clean_q, clean_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  state_e        state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          rise, fall, rep;

  always_comb begin
    clean_d = clean_q;
    dcnt_d  = dcnt_q;
    if (sync2_q == clean_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DB_T) begin
      clean_d = sync2_q;
      dcnt_d  = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
    rise = clean_d & ~clean_q;
    fall = ~clean_d & clean_q;

    // An accepted fall outranks a repeat terminal count in the same cycle.
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rep     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HOLD;
          rcnt_d  = '0;
        end
      end
      HOLD, REPEAT: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (!repeat_en_in) begin
          state_d = HOLD;
          rcnt_d  = '0;
        end else if (rcnt_q == ((state_q == HOLD) ? DLY_T : PER_T)) begin
          rep     = 1'b1;
          state_d = REPEAT;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase

    press_d   = rise | rep;
    release_d = fall;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      clean_q   <= 1'b0;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      clean_q   <= clean_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign clean_out   = clean_q;
  assign press_out   = press_q;
  assign release_out = release_q;
endmodule

module btn_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] btn_in,
  input  logic [WIDTH-1:0] repeat_en_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] press_out,
  output logic [WIDTH-1:0] release_out
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    btn_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .btn_in      (btn_in[i]),
      .repeat_en_in(repeat_en_in[i]),
      .clean_out   (clean_out[i]),
      .press_out   (press_out[i]),
      .release_out (release_out[i])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulse events are queued by the
// stimulus and popped by a monitor whenever the DUT emits press/release.

module tb_btn_conditioner;
  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [3:0] btn_in, repeat_en_in;
  logic [3:0] clean_out, press_out, release_out;

  btn_conditioner #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(btn_in), .repeat_en_in(repeat_en_in),
    .clean_out(clean_out), .press_out(press_out), .release_out(release_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] cl;
  } ev_t;

  ev_t q[$];
  int  compared = 0;
  int  mismatched = 0;

  task automatic push(input int c, input logic [3:0] pr, input logic [3:0] rl,
                      input logic [3:0] cl);
    ev_t e;
    e.cyc = c; e.pr = pr; e.rl = rl; e.cl = cl;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin @(posedge clk_in); #1; end
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got=%b want=%b (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk_in);
      if ((press_out | release_out) != 4'b0000) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b clean=%b",
                   cyc, press_out, release_out, clean_out);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || press_out !== e.pr || release_out !== e.rl || clean_out !== e.cl) begin
            mismatched++;
            $display("FAIL pulse_event got cyc=%0d press=%b release=%b clean=%b want cyc=%0d press=%b release=%b clean=%b",
                     cyc, press_out, release_out, clean_out, e.cyc, e.pr, e.rl, e.cl);
          end
        end
      end
    end
  endtask

  initial begin
    int p, r;
    rst_in = 1'b1; btn_in = '0; repeat_en_in = '0;
    fork monitor(); join_none
    step(2);
    chk("reset_clean", clean_out, 4'b0000);
    chk("reset_press", press_out, 4'b0000);
    chk("reset_release", release_out, 4'b0000);
    rst_in = 1'b0;
    step(2);

    // basic press / release on channel 1
    btn_in = 4'b0010; push(cyc + 6, 4'b0010, 4'b0000, 4'b0010);
    step(10);
    chk("basic_clean_held", clean_out, 4'b0010);
    btn_in = 4'b0000; push(cyc + 6, 4'b0000, 4'b0010, 4'b0000);
    step(10);
    chk("basic_clean_released", clean_out, 4'b0000);

    // glitches of at most 3 synchronised cycles are swallowed
    btn_in = 4'b0001; step(3); btn_in = 4'b0000; step(3);
    for (int k = 0; k < 2; k++) begin
      btn_in = 4'b0001; step(3); btn_in = 4'b0000; step(1);
    end
    step(8);
    chk("glitch_clean", clean_out, 4'b0000);
    // exactly 4 stable cycles is accepted; the fall then follows 6 edges after drop
    btn_in = 4'b0001; push(cyc + 6, 4'b0001, 4'b0000, 4'b0001); push(cyc + 10, 4'b0000, 4'b0001, 4'b0000);
    step(4); btn_in = 4'b0000;
    step(12);

    // auto-repeat; release lands on a repeat terminal count
    repeat_en_in = 4'b0010;
    btn_in = 4'b0010; p = cyc + 6;
    push(p, 4'b0010, 4'b0000, 4'b0010);
    for (int k = 0; k < 9; k++) push(p + 10 + 3 * k, 4'b0010, 4'b0000, 4'b0010);
    push(p + 37, 4'b0000, 4'b0010, 4'b0000);
    wait_until(p + 31); btn_in = 4'b0000;
    step(12);

    // repeat disabled from P+6..P+8 restarts the full delay
    btn_in = 4'b0010; p = cyc + 6;
    push(p, 4'b0010, 4'b0000, 4'b0010);
    push(p + 18, 4'b0010, 4'b0000, 4'b0010);
    push(p + 21, 4'b0010, 4'b0000, 4'b0010);
    push(p + 24, 4'b0010, 4'b0000, 4'b0010);
    push(p + 26, 4'b0000, 4'b0010, 4'b0000);
    wait_until(p + 5); repeat_en_in = 4'b0000;
    wait_until(p + 8); repeat_en_in = 4'b0010;
    wait_until(p + 20); btn_in = 4'b0000;
    step(12);
    repeat_en_in = 4'b0000;

    // all channels together, then reset while held
    btn_in = 4'b1111; push(cyc + 6, 4'b1111, 4'b0000, 4'b1111);
    step(10);
    chk("multi_clean", clean_out, 4'b1111);
    rst_in = 1'b1; #1;
    chk("midreset_clean", clean_out, 4'b0000);
    chk("midreset_press", press_out, 4'b0000);
    chk("midreset_release", release_out, 4'b0000);
    step(3);
    rst_in = 1'b0; r = cyc;
    push(r + 6, 4'b1111, 4'b0000, 4'b1111);
    wait_until(r + 5);
    chk("postreset_clean_pre", clean_out, 4'b0000);
    wait_until(r + 10);
    btn_in = 4'b0000; push(cyc + 6, 4'b0000, 4'b1111, 4'b0000);
    step(12);
    chk("final_clean", clean_out, 4'b0000);

    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      compared++; mismatched++;
      $display("FAIL missing_event got none want cyc=%0d press=%b release=%b", e.cyc, e.pr, e.rl);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
